// File: rtl/audio_pkg.sv
// audio_pkg: capture FSM states and shared audio-path constants
package audio_pkg;
  typedef enum logic [1:0] {CAP_IDLE, CAP_ARM, CAP_CAPTURE, CAP_DONE} cap_state_t;
  localparam int SAMPLE_W = 32;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_DECIM = 128;
endpackage

// File: rtl/pdm_clk_gen.sv
// pdm_clk_gen: divides clk into the microphone clock and flags the bit-sample cycle
module pdm_clk_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic pdm_clk,
  output logic strobe
);
  localparam int DW = $clog2(CLK_DIV);
  logic [DW-1:0] div;
  logic wrap;
  assign wrap = div == DW'(CLK_DIV - 1);
  assign strobe = en & wrap & pdm_clk;
  // divider runs only while enabled; pdm_clk idles low otherwise
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div <= '0;
      pdm_clk <= 1'b0;
    end else begin
      div <= wrap ? '0 : div + DW'(1);
      pdm_clk <= wrap ? ~pdm_clk : pdm_clk;
    end
  end
endmodule

// File: rtl/pdm_mic_capture.sv
// pdm_mic_capture: clocks a PDM mic, boxcar-decimates its bits and writes samples to memory
module pdm_mic_capture
  import audio_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV,
  parameter int DECIM = DEF_DECIM,
  parameter int ADDR_W = 16,
  parameter int DEPTH = 65536
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rec_en,
  input  logic                pdm_data,
  output logic                pdm_clk,
  output logic                pdm_lrsel,
  output logic                wr_en,
  output logic [ADDR_W-1:0]   wr_addr,
  output logic [SAMPLE_W-1:0] wr_data,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W:0]     sample_cnt
);
  localparam int AW = $clog2(DECIM);
  cap_state_t state;
  logic [AW:0] acc, acc_next;
  logic [AW-1:0] bits;
  logic strobe, last_bit, last_addr;
  pdm_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk(clk),
    .rst(rst),
    .en(state == CAP_CAPTURE),
    .pdm_clk(pdm_clk),
    .strobe(strobe)
  );
  assign pdm_lrsel = 1'b0;
  assign busy = state == CAP_ARM || state == CAP_CAPTURE;
  assign done = state == CAP_DONE;
  assign acc_next = acc + (AW + 1)'(pdm_data);
  assign last_bit = bits == AW'(DECIM - 1);
  assign last_addr = wr_addr == ADDR_W'(DEPTH - 1);
  // capture FSM, accumulator and write-side bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CAP_IDLE;
      acc <= '0;
      bits <= '0;
      wr_en <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      sample_cnt <= '0;
    end else begin
      wr_en <= 1'b0;
      if (wr_en) begin
        sample_cnt <= sample_cnt + (ADDR_W + 1)'(1);
        wr_addr <= last_addr ? wr_addr : wr_addr + ADDR_W'(1);
      end
      case (state)
        CAP_IDLE: if (rec_en) begin
          state <= CAP_ARM;
          sample_cnt <= '0;
          wr_addr <= '0;
        end
        CAP_ARM: begin
          acc <= '0;
          bits <= '0;
          state <= rec_en ? CAP_CAPTURE : CAP_IDLE;
        end
        CAP_CAPTURE: begin
          state <= !rec_en ? CAP_IDLE : (wr_en && last_addr) ? CAP_DONE : CAP_CAPTURE;
          if (strobe) begin
            bits <= bits + AW'(1);
            acc <= last_bit ? '0 : acc_next;
          end
          if (strobe && last_bit && rec_en) begin
            wr_en <= 1'b1;
            wr_data <= SAMPLE_W'(acc_next);
          end
        end
        default: state <= rec_en ? CAP_DONE : CAP_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_pdm_mic_capture.sv
// tb_pdm_mic_capture: directed checks of PDM clocking, decimation, abort, reset and address boundary
module tb_pdm_mic_capture;
  logic clk = 1'b0;
  logic rst, rec_en, pdm_data, rec_en_b, pdm_data_b;
  logic pdm_clk, pdm_lrsel, wr_en, busy, done;
  logic [15:0] wr_addr;
  logic [31:0] wr_data;
  logic [16:0] sample_cnt;
  logic pdm_clk_b, pdm_lrsel_b, wr_en_b, busy_b, done_b;
  logic [2:0] wr_addr_b;
  logic [31:0] wr_data_b;
  logic [3:0] sample_cnt_b;
  int errors = 0, checks = 0, cyc = 0;
  int k, n, t, tprev, falls, writes, last_addr;
  bit ok, prev, d;

  pdm_mic_capture #(.CLK_DIV(4), .DECIM(128), .ADDR_W(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .rec_en(rec_en), .pdm_data(pdm_data),
    .pdm_clk(pdm_clk), .pdm_lrsel(pdm_lrsel), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(busy), .done(done), .sample_cnt(sample_cnt)
  );

  pdm_mic_capture #(.CLK_DIV(4), .DECIM(128), .ADDR_W(3), .DEPTH(8)) dut_b (
    .clk(clk), .rst(rst), .rec_en(rec_en_b), .pdm_data(pdm_data_b),
    .pdm_clk(pdm_clk_b), .pdm_lrsel(pdm_lrsel_b), .wr_en(wr_en_b), .wr_addr(wr_addr_b),
    .wr_data(wr_data_b), .busy(busy_b), .done(done_b), .sample_cnt(sample_cnt_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_wr(input int budget, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (wr_en) begin
        hit = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    rst = 1'b1; rec_en = 1'b0; pdm_data = 1'b0; rec_en_b = 1'b0; pdm_data_b = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pdm_clk", pdm_clk, 0);
    chk("rst_addr", wr_addr, 0);
    chk("rst_cnt", sample_cnt, 0);
    chk("rst_data", wr_data, 0);
    chk("lrsel", pdm_lrsel, 0);
    rst = 1'b0;
    // full recording of all-ones data, DEPTH=4
    pdm_data = 1'b1; rec_en = 1'b1;
    @(negedge clk);
    chk("arm_busy", busy, 1);
    k = 1;
    while (!pdm_clk && k < 20) begin @(negedge clk); k++; end
    chk("first_rise", k, 6);
    n = 0;
    while (pdm_clk && n < 20) begin @(negedge clk); n++; end
    chk("pdm_high", n, 4);
    n = 0;
    while (!pdm_clk && n < 20) begin @(negedge clk); n++; end
    chk("pdm_low", n, 4);
    tprev = 0;
    for (int i = 0; i < 4; i++) begin
      wait_wr(1100, ok);
      t = cyc;
      chk("wr_seen", ok, 1);
      chk("wr_addr", wr_addr, i);
      chk("wr_data_ones", wr_data, 128);
      if (i > 0) chk("wr_gap", t - tprev, 1024);
      tprev = t;
    end
    @(negedge clk);
    chk("wr_pulse", wr_en, 0);
    chk("done_set", done, 1);
    chk("done_busy", busy, 0);
    chk("done_cnt", sample_cnt, 4);
    chk("done_addr", wr_addr, 3);
    n = 0; d = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (wr_en) n++;
      if (!done || pdm_clk) d = 1'b0;
    end
    chk("done_hold_wr", n, 0);
    chk("done_hold", d, 1);
    rec_en = 1'b0;
    @(negedge clk);
    chk("done_clear", done, 0);
    // all-zeros sample, then abort in the write cycle
    pdm_data = 1'b0; rec_en = 1'b1;
    wait_wr(1200, ok);
    chk("zero_seen", ok, 1);
    chk("zero_data", wr_data, 0);
    chk("zero_addr", wr_addr, 0);
    rec_en = 1'b0;
    @(negedge clk);
    chk("abort_wr_cnt", sample_cnt, 1);
    chk("abort_wr_busy", busy, 0);
    @(negedge clk);
    // alternating bits, toggled after each pdm_clk rise
    rec_en = 1'b1; prev = 1'b0; ok = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (pdm_clk && !prev) pdm_data = ~pdm_data;
      prev = pdm_clk;
      if (wr_en) begin ok = 1'b1; break; end
    end
    chk("alt_seen", ok, 1);
    chk("alt_data", wr_data, 64);
    rec_en = 1'b0;
    repeat (2) @(negedge clk);
    // abort after 300 strobes
    pdm_data = 1'b1; rec_en = 1'b1; falls = 0; writes = 0; prev = 1'b0;
    for (int i = 0; i < 4000 && falls < 300; i++) begin
      @(negedge clk);
      if (wr_en) writes++;
      if (prev && !pdm_clk) falls++;
      prev = pdm_clk;
    end
    rec_en = 1'b0;
    chk("abort_strobes", falls, 300);
    chk("abort_writes", writes, 2);
    @(negedge clk);
    chk("abort_busy", busy, 0);
    n = 0;
    repeat (1100) begin @(negedge clk); if (wr_en) n++; end
    chk("abort_no_wr", n, 0);
    chk("abort_cnt", sample_cnt, 2);
    chk("abort_done", done, 0);
    chk("abort_pdm_clk", pdm_clk, 0);
    // restart after abort
    rec_en = 1'b1;
    wait_wr(1200, ok);
    chk("restart_seen", ok, 1);
    chk("restart_addr", wr_addr, 0);
    @(negedge clk);
    chk("restart_cnt", sample_cnt, 1);
    // reset in the middle of capture
    repeat (500) @(negedge clk);
    chk("mid_busy", busy, 1);
    rst = 1'b1; rec_en = 1'b0;
    @(negedge clk);
    chk("mrst_busy", busy, 0);
    chk("mrst_wr_en", wr_en, 0);
    chk("mrst_addr", wr_addr, 0);
    chk("mrst_data", wr_data, 0);
    chk("mrst_cnt", sample_cnt, 0);
    chk("mrst_pdm_clk", pdm_clk, 0);
    chk("mrst_done", done, 0);
    rst = 1'b0;
    // address boundary: DEPTH = 2^ADDR_W
    rec_en_b = 1'b1; n = 0; last_addr = -1;
    for (int i = 0; i < 9000; i++) begin
      @(negedge clk);
      if (wr_en_b) begin n++; last_addr = wr_addr_b; end
      if (done_b) break;
    end
    chk("b_writes", n, 8);
    chk("b_last_addr", last_addr, 7);
    chk("b_done", done_b, 1);
    chk("b_cnt", sample_cnt_b, 8);
    chk("b_addr_hold", wr_addr_b, 7);
    chk("b_data", wr_data_b, 128);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pdm_mic_capture.md
Name: pdm_mic_capture

Overview:
- Record-side counterpart of the PWM playback path: clocks a PDM microphone, decimates its 1-bit stream into unsigned samples, and writes them sequentially into a 32-bit sample memory.
- The playback path later reads the same memory and feeds the samples to the PWM generator.
- Runs in the divided audio clock domain (CLK100MHZ/8 = 12.5 MHz).
- With the defaults, the sample rate equals the playback rate: 12.5 MHz / (2·4·128) ≈ 12.2 kHz, matching the /1024 data clock.

Parameters:
- CLK_DIV, 4: clk cycles per pdm_clk half-period; pdm_clk period = 2·CLK_DIV clk cycles; must be ≥ 2.
- DECIM, 128: PDM bits accumulated per sample (boxcar decimation); must be a power of two.
- ADDR_W, 16: width of the write address.
- DEPTH, 65536: samples per recording; must be ≤ 2^ADDR_W and ≥ 1.

Ports:
- clk  in  1  audio-domain clock.
- rst  in  1  synchronous reset, active-high.
- rec_en  in  1  level; high = record; already synchronised to clk.
- pdm_data  in  1  microphone data bit.
- pdm_clk  out  1  microphone clock.
- pdm_lrsel  out  1  channel select; constant 0.
- wr_en  out  1  one-cycle write strobe to the sample memory.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  32  sample = ones count, zero-extended.
- busy  out  1  high in ARM or CAPTURE.
- done  out  1  recording complete; held until rec_en falls.
- sample_cnt  out  ADDR_W+1  samples written in the current or last recording.

Behaviour:
- Reset (rst=1 at posedge): FSM to IDLE; all outputs 0; all internal counters 0. rst has priority over every other event.
- Decided: one clock; reset is synchronous and active-high (clk, rst).
- FSM states: IDLE, ARM, CAPTURE, DONE.
- IDLE:
  - pdm_clk held 0.
  - rec_en=1 → ARM; on this transition, sample_cnt and wr_addr clear to 0.
- ARM: one cycle only; clears the divider, bit counter and ones accumulator; → CAPTURE.
- CAPTURE, clock generation:
  - Divider counts 0..CLK_DIV-1.
  - pdm_clk toggles at each wrap of the divider.
  - First rising edge of pdm_clk occurs CLK_DIV cycles after entering CAPTURE.
- CAPTURE, bit strobe:
  - Strobe = divider == CLK_DIV-1 and pdm_clk == 1 (the cycle before the falling edge).
  - On each strobe, pdm_data is added to the accumulator and the bit counter increments.
- CAPTURE, sample completion (DECIM-th strobe):
  - Next cycle: wr_en=1, wr_data = accumulator (range 0..DECIM; width log2(DECIM)+1, zero-extended to 32), wr_addr = current address.
  - Accumulator and bit counter restart without losing a bit; the strobe of that same cycle counts toward the next sample.
  - After each write: wr_addr increments and sample_cnt increments.
- DONE entry:
  - The write at address DEPTH-1 → DONE on the following cycle.
  - wr_addr stays at DEPTH-1; it does not wrap.
  - sample_cnt = DEPTH.
- DONE: pdm_clk = 0, done = 1, busy = 0; rec_en=0 → IDLE with done cleared.
- Abort:
  - rec_en falls in ARM or CAPTURE → IDLE next cycle.
  - The partial sample is discarded; no wr_en is issued.
  - sample_cnt keeps the number of completed writes; done stays 0.
  - If the abort cycle coincides with a pending wr_en cycle, that write still completes.
- Simultaneous events: wr_en fires in the same cycle a strobe occurs → both are handled.
- Outputs change only at posedge clk; wr_en is never asserted in IDLE or DONE.

Decomposition:
- Shared package audio_pkg: FSM state enum (CAP_IDLE, CAP_ARM, CAP_CAPTURE, CAP_DONE), SAMPLE_W = 32, default CLK_DIV/DECIM localparams.
- One natural sub-module: pdm_clk_gen (divider, pdm_clk, bit strobe; enable input). Accumulator and FSM stay in the top block.

Test Plan:
- pdm_data=1 constant, DEPTH=4, rec_en=1 → four wr_en pulses, wr_addr 0..3, wr_data=128 each, then done=1, sample_cnt=4.
- pdm_data=0 constant → wr_data=0. Alternating bits driven after each pdm_clk rising edge → wr_data=64.
- Measure pdm_clk → period 8 clk cycles with 50% duty; first rising edge 4 cycles after CAPTURE entry; gap between wr_en pulses = 1024 clk cycles.
- rec_en dropped after 300 strobes (sample 2 partial) → no third write, IDLE, done=0, sample_cnt=2. Re-raise rec_en → wr_addr restarts at 0.
- rst=1 mid-CAPTURE → next cycle all outputs 0, FSM IDLE. In DONE, hold rec_en=1 for 100 cycles → done stays 1, no wr_en.
- Boundary: DEPTH = 2^ADDR_W with ADDR_W=3 → last write at address 7, sample_cnt=8, wr_addr does not wrap.
